// File: rtl/l2_msg_pkg.sv
// ============================================================================
// Module      : l2_msg_pkg
// Description : Shared constants and channel-state type for the L2 msg2
//               outgoing message path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2_msg_pkg;

    localparam int L2_MSG_TYPE_W = 8;
    localparam int L2_MSG_TAG_W  = 26;
    localparam int L2_MSG_DATA_W = 64;

    localparam logic [7:0] MSG2_TYPE_NONE    = 8'h00;
    localparam logic [7:0] MSG2_TYPE_WB_REQ  = 8'h12;
    localparam logic [7:0] MSG2_TYPE_INV_ACK = 8'h21;
    localparam logic [7:0] MSG2_TYPE_DATA    = 8'h22;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } ch_state_e;

endpackage

`default_nettype wire

// File: rtl/l2_msg_skid_ch.sv
// ============================================================================
// Module      : l2_msg_skid_ch
// Description : One outgoing channel: 2-entry skid buffer, saturating
//               consecutive-stall counter and sticky timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_msg_skid_ch
    import l2_msg_pkg::*;
#(
    parameter int MSG_W       = 98,
    parameter int CNT_W       = 8,
    parameter int STALL_LIMIT = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MSG_W-1:0] in_msg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MSG_W-1:0] out_msg,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_timeout,
    input  logic             clear_timeout
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_limit   = CNT_W'(STALL_LIMIT);

    ch_state_e          r_state;
    ch_state_e          w_state_next;
    logic [MSG_W-1:0]   r_head;
    logic [MSG_W-1:0]   r_skid;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_timeout;
    logic               w_enq;
    logic               w_deq;
    logic               w_stall;
    logic               w_set_timeout;
    logic               w_load_head;
    logic               w_load_skid;
    logic               w_head_from_skid;

    // Handshake decodes use registered state only, so in_ready never
    // combinationally depends on out_ready.
    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_enq     = in_valid & in_ready;
    assign w_deq     = out_valid & out_ready;
    assign w_stall   = out_valid & ~out_ready;

    assign out_msg       = r_head;
    assign stall_cnt     = r_cnt;
    assign stall_timeout = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_load_head      = 1'b0;
        w_load_skid      = 1'b0;
        w_head_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_enq) begin
                    w_state_next = ST_ONE;
                    w_load_head  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_enq && w_deq) begin
                    w_load_head = 1'b1;
                end else if (w_enq) begin
                    w_state_next = ST_TWO;
                    w_load_skid  = 1'b1;
                end else if (w_deq) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_deq) begin
                    w_state_next     = ST_ONE;
                    w_head_from_skid = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // Head only changes when empty or on a dequeue, which keeps out_msg
    // bit-stable for the whole duration of a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head) begin
                r_head <= in_msg;
            end else if (w_head_from_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_msg;
            end
        end
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_deq) begin
            w_cnt_next = '0;
        end else if (w_stall) begin
            w_cnt_next = (r_cnt == c_cnt_max) ? c_cnt_max : r_cnt + 1'b1;
        end
    end

    assign w_set_timeout = w_stall && (w_cnt_next >= c_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end else if (clear_timeout) begin
                r_timeout <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/l2_msg_out_stall_buffer.sv
// ============================================================================
// Module      : l2_msg_out_stall_buffer
// Description : NUM_CH independent msg2 output channels, each with a 2-entry
//               skid buffer and stall accounting; any_stall ORs all channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_msg_out_stall_buffer
    import l2_msg_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int TYPE_W      = L2_MSG_TYPE_W,
    parameter int TAG_W       = L2_MSG_TAG_W,
    parameter int DATA_W      = L2_MSG_DATA_W,
    parameter int CNT_W       = 8,
    parameter int STALL_LIMIT = 200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*TYPE_W-1:0] in_type,
    input  logic [NUM_CH*TAG_W-1:0]  in_tag,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*TYPE_W-1:0] out_type,
    output logic [NUM_CH*TAG_W-1:0]  out_tag,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH*CNT_W-1:0]  stall_cnt,
    output logic [NUM_CH-1:0]        stall_timeout,
    input  logic [NUM_CH-1:0]        clear_timeout,
    output logic                     any_stall
);

    localparam int c_msg_w = TYPE_W + TAG_W + DATA_W;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [c_msg_w-1:0] w_in_msg;
        logic [c_msg_w-1:0] w_out_msg;

        // Message packed as {type, tag, data}, type in the MSBs.
        assign w_in_msg = {in_type[i*TYPE_W +: TYPE_W],
                           in_tag[i*TAG_W +: TAG_W],
                           in_data[i*DATA_W +: DATA_W]};

        assign out_type[i*TYPE_W +: TYPE_W] = w_out_msg[c_msg_w-1 -: TYPE_W];
        assign out_tag[i*TAG_W +: TAG_W]    = w_out_msg[DATA_W +: TAG_W];
        assign out_data[i*DATA_W +: DATA_W] = w_out_msg[DATA_W-1:0];

        l2_msg_skid_ch #(
            .MSG_W       (c_msg_w),
            .CNT_W       (CNT_W),
            .STALL_LIMIT (STALL_LIMIT)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .in_valid      (in_valid[i]),
            .in_ready      (in_ready[i]),
            .in_msg        (w_in_msg),
            .out_valid     (out_valid[i]),
            .out_ready     (out_ready[i]),
            .out_msg       (w_out_msg),
            .stall_cnt     (stall_cnt[i*CNT_W +: CNT_W]),
            .stall_timeout (stall_timeout[i]),
            .clear_timeout (clear_timeout[i])
        );
    end

    assign any_stall = |(out_valid & ~out_ready);

endmodule

`default_nettype wire

// File: tb/tb_l2_msg_out_stall_buffer.sv
// ============================================================================
// Module      : tb_l2_msg_out_stall_buffer
// Description : Directed self-checking bench for l2_msg_out_stall_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_msg_out_stall_buffer;

    localparam int NUM_CH = 3;
    localparam int TYPE_W = 8;
    localparam int TAG_W  = 26;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 8;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*TYPE_W-1:0] in_type;
    logic [NUM_CH*TAG_W-1:0]  in_tag;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*TYPE_W-1:0] out_type;
    logic [NUM_CH*TAG_W-1:0]  out_tag;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH*CNT_W-1:0]  stall_cnt;
    logic [NUM_CH-1:0]        stall_timeout;
    logic [NUM_CH-1:0]        clear_timeout;
    logic                     any_stall;

    int errors = 0;
    int checks = 0;

    l2_msg_out_stall_buffer #(
        .NUM_CH      (NUM_CH),
        .TYPE_W      (TYPE_W),
        .TAG_W       (TAG_W),
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .STALL_LIMIT (200)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_type       (in_type),
        .in_tag        (in_tag),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_type      (out_type),
        .out_tag       (out_tag),
        .out_data      (out_data),
        .stall_cnt     (stall_cnt),
        .stall_timeout (stall_timeout),
        .clear_timeout (clear_timeout),
        .any_stall     (any_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic [7:0] t, input logic [25:0] g,
                         input logic [63:0] d);
        in_type[ch*TYPE_W +: TYPE_W] = t;
        in_tag[ch*TAG_W +: TAG_W]    = g;
        in_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = '0; out_ready = '0; clear_timeout = '0;
        in_type = '0; in_tag = '0; in_data = '0;
        #12;
        checks++;
        if (in_ready !== 3'b111) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=111", in_ready);
        end
        checks++;
        if (out_valid !== 3'b000 || any_stall !== 1'b0 || stall_timeout !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got valid=%b stall=%b to=%b exp 000/0/000",
                     out_valid, any_stall, stall_timeout);
        end
        checks++;
        if (out_type !== '0 || out_tag !== '0 || out_data !== '0 || stall_cnt !== '0) begin
            errors++; $display("FAIL reset_payload got type=%h cnt=%h exp all zero",
                               out_type, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 3'b111 || out_valid !== 3'b000) begin
            errors++; $display("FAIL idle got ready=%b valid=%b exp 111/000", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        out_ready = 3'b111;
        drive(0, 8'h12, 26'h1, 64'hA5A5_0000_0000_0001);
        in_valid = 3'b001;
        tick();
        in_valid = '0;
        checks++;
        if (out_valid[0] !== 1'b1 || out_type[7:0] !== 8'h12 || out_tag[25:0] !== 26'h1
            || out_data[63:0] !== 64'hA5A5_0000_0000_0001) begin
            errors++;
            $display("FAIL single_out got v=%b type=%h tag=%h data=%h exp 1/12/1/a5a5000000000001",
                     out_valid[0], out_type[7:0], out_tag[25:0], out_data[63:0]);
        end
        tick();
        checks++;
        if (out_valid[0] !== 1'b0 || stall_cnt[7:0] !== 8'd0) begin
            errors++; $display("FAIL single_drain got v=%b cnt=%0d exp 0/0",
                               out_valid[0], stall_cnt[7:0]);
        end
    endtask

    task automatic test_stall_two();
        out_ready = 3'b101;
        drive(1, 8'h21, 26'h100, 64'h1111);
        in_valid = 3'b010;
        tick();
        checks++;
        if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b1 || any_stall !== 1'b1) begin
            errors++; $display("FAIL stall_one got rdy=%b v=%b any=%b exp 1/1/1",
                               in_ready[1], out_valid[1], any_stall);
        end
        drive(1, 8'h22, 26'h200, 64'h2222);
        tick();
        in_valid = '0;
        checks++;
        if (in_ready[1] !== 1'b0 || stall_cnt[15:8] !== 8'd1) begin
            errors++; $display("FAIL stall_two got rdy=%b cnt=%0d exp 0/1",
                               in_ready[1], stall_cnt[15:8]);
        end
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++;
            if (out_type[15:8] !== 8'h21 || out_tag[51:26] !== 26'h100
                || out_data[127:64] !== 64'h1111 || out_valid[1] !== 1'b1) begin
                errors++; $display("FAIL stall_hold cyc=%0d got type=%h tag=%h exp 21/100",
                                   k, out_type[15:8], out_tag[51:26]);
            end
        end
        checks++;
        if (stall_cnt[15:8] !== 8'd10) begin
            errors++; $display("FAIL stall_cnt10 got=%0d exp=10", stall_cnt[15:8]);
        end
        out_ready = 3'b111;
        #1;
        checks++;
        if (any_stall !== 1'b0) begin
            errors++; $display("FAIL any_stall_release got=%b exp=0", any_stall);
        end
        tick();
        checks++;
        if (out_type[15:8] !== 8'h22 || out_tag[51:26] !== 26'h200
            || out_data[127:64] !== 64'h2222 || stall_cnt[15:8] !== 8'd0 || in_ready[1] !== 1'b1) begin
            errors++; $display("FAIL drain_second got type=%h cnt=%0d rdy=%b exp 22/0/1",
                               out_type[15:8], stall_cnt[15:8], in_ready[1]);
        end
        tick();
        checks++;
        if (out_valid[1] !== 1'b0) begin
            errors++; $display("FAIL drain_empty got v=%b exp=0", out_valid[1]);
        end
    endtask

    task automatic test_timeout();
        out_ready = 3'b011;
        drive(2, 8'h33, 26'h3, 64'h3333);
        in_valid = 3'b100;
        tick();
        in_valid = '0;
        for (int k = 0; k < 199; k++) tick();
        checks++;
        if (stall_cnt[23:16] !== 8'd199 || stall_timeout[2] !== 1'b0) begin
            errors++; $display("FAIL timeout_pre got cnt=%0d to=%b exp 199/0",
                               stall_cnt[23:16], stall_timeout[2]);
        end
        tick();
        checks++;
        if (stall_cnt[23:16] !== 8'd200 || stall_timeout[2] !== 1'b1) begin
            errors++; $display("FAIL timeout_set got cnt=%0d to=%b exp 200/1",
                               stall_cnt[23:16], stall_timeout[2]);
        end
        clear_timeout = 3'b100;
        tick();
        clear_timeout = '0;
        checks++;
        if (stall_timeout[2] !== 1'b1 || stall_cnt[23:16] !== 8'd201) begin
            errors++; $display("FAIL set_wins got to=%b cnt=%0d exp 1/201",
                               stall_timeout[2], stall_cnt[23:16]);
        end
        for (int k = 0; k < 99; k++) tick();
        checks++;
        if (stall_cnt[23:16] !== 8'd255) begin
            errors++; $display("FAIL saturate got=%0d exp=255", stall_cnt[23:16]);
        end
        out_ready = 3'b111;
        tick();
        checks++;
        if (stall_timeout[2] !== 1'b1 || stall_cnt[23:16] !== 8'd0 || out_valid[2] !== 1'b0) begin
            errors++; $display("FAIL sticky got to=%b cnt=%0d v=%b exp 1/0/0",
                               stall_timeout[2], stall_cnt[23:16], out_valid[2]);
        end
        clear_timeout = 3'b100;
        tick();
        clear_timeout = '0;
        checks++;
        if (stall_timeout[2] !== 1'b0) begin
            errors++; $display("FAIL clear got=%b exp=0", stall_timeout[2]);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 3'b111;
        for (int c = 0; c < NUM_CH; c++)
            drive(c, 8'(c*16), 26'(c), {32'(c), 32'd0});
        in_valid = 3'b111;
        tick();
        for (int k = 0; k < 50; k++) begin
            for (int c = 0; c < NUM_CH; c++)
                drive(c, 8'(c*16 + k + 1), 26'((k+1)*3 + c), {32'(c), 32'(k+1)});
            checks++;
            if (in_ready !== 3'b111 || out_valid !== 3'b111) begin
                errors++; $display("FAIL b2b_flow k=%0d got rdy=%b v=%b exp 111/111",
                                   k, in_ready, out_valid);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                checks++;
                if (out_type[c*TYPE_W +: TYPE_W] !== 8'(c*16 + k)
                    || out_tag[c*TAG_W +: TAG_W] !== 26'(k*3 + c)
                    || out_data[c*DATA_W +: DATA_W] !== {32'(c), 32'(k)}) begin
                    errors++;
                    $display("FAIL b2b_order k=%0d ch=%0d got type=%h exp=%h",
                             k, c, out_type[c*TYPE_W +: TYPE_W], 8'(c*16 + k));
                end
            end
            tick();
        end
        in_valid = '0;
        checks++;
        if (out_type[7:0] !== 8'd50 || out_valid !== 3'b111) begin
            errors++; $display("FAIL b2b_last got type=%h v=%b exp 32/111",
                               out_type[7:0], out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 3'b000 || stall_cnt !== '0) begin
            errors++; $display("FAIL b2b_end got v=%b cnt=%h exp 000/0", out_valid, stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 3'b101;
        drive(1, 8'h44, 26'h4, 64'h4444);
        in_valid = 3'b010;
        tick();
        drive(1, 8'h55, 26'h5, 64'h5555);
        tick();
        in_valid = '0;
        for (int k = 0; k < 199; k++) tick();
        checks++;
        if (in_ready[1] !== 1'b0 || stall_timeout[1] !== 1'b1 || stall_cnt[15:8] !== 8'd200) begin
            errors++; $display("FAIL pre_reset got rdy=%b to=%b cnt=%0d exp 0/1/200",
                               in_ready[1], stall_timeout[1], stall_cnt[15:8]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[1] !== 1'b0 || stall_cnt[15:8] !== 8'd0 || stall_timeout[1] !== 1'b0
            || in_ready !== 3'b111 || out_type !== '0) begin
            errors++; $display("FAIL async_reset got v=%b cnt=%0d to=%b rdy=%b exp 0/0/0/111",
                               out_valid[1], stall_cnt[15:8], stall_timeout[1], in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 3'b111;
        tick();
        checks++;
        if (out_valid !== 3'b000 || any_stall !== 1'b0) begin
            errors++; $display("FAIL post_reset got v=%b any=%b exp 000/0", out_valid, any_stall);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_two();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/l2_msg_out_stall_buffer.md
# l2_msg_out_stall_buffer

Parametrised output-side buffer for the L2 outgoing message channels (msg2 class). It holds each outgoing message stable while the NoC applies backpressure and gives every channel a 2-entry skid so the L2 pipeline can drain one cycle late. It also counts consecutive stall cycles per channel and raises a sticky timeout. It generalises the single-channel "msg2 asserted, hold all state" behaviour to NUM_CH independent channels with buffering and stall accounting.

## Interface
- NUM_CH, 3, number of independent outgoing message channels
- TYPE_W, 8, message type width
- TAG_W, 26, message tag width
- DATA_W, 64, message data width
- CNT_W, 8, stall counter width; saturates at 2^CNT_W-1
- STALL_LIMIT, 200, stall cycles at which timeout is set; must be 1..2^CNT_W-1
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  NUM_CH  L2 pipeline offers message on channel i
- in_ready  out  NUM_CH  channel i can accept
- in_type / in_tag / in_data  in  NUM_CH*TYPE_W / NUM_CH*TAG_W / NUM_CH*DATA_W  flattened payload, channel i at slice i
- out_valid  out  NUM_CH  message presented to NoC
- out_ready  in  NUM_CH  NoC accepts
- out_type / out_tag / out_data  out  flattened, same layout as inputs
- stall_cnt  out  NUM_CH*CNT_W  current consecutive-stall count per channel
- stall_timeout  out  NUM_CH  sticky timeout flag
- clear_timeout  in  NUM_CH  clears flag i
- any_stall  out  1  OR over channels of (out_valid & ~out_ready)

## Operation
- Channels are fully independent; no arbitration.
- Per channel state: EMPTY, ONE, TWO (entries held). Head entry drives out_*; skid entry holds second message.
- in_ready[i] = (state != TWO), decoded from registered state only; no combinational path from out_ready.
- out_valid[i] = (state != EMPTY).
- Enqueue = in_valid & in_ready; dequeue = out_valid & out_ready.
- EMPTY: enq -> ONE (head <= input).
- ONE: enq&deq -> ONE (head <= input); enq only -> TWO (skid <= input); deq only -> EMPTY.
- TWO: deq -> ONE (head <= skid); no enq possible.
- While out_valid & ~out_ready, out_type/tag/data and out_valid hold bit-identical (hold rule).
- Stall counter: stall cycle -> cnt <= min(cnt+1, 2^CNT_W-1); dequeue cycle -> cnt <= 0; otherwise hold.
- Timeout: set when counter update makes cnt == STALL_LIMIT (or already ≥); stays set until clear_timeout[i] or reset. clear and set in same cycle: set wins.
- Payload in empty slots is don't-care, but out_* read 0 after reset.

## Timing
- Reset (rst low, async assert, synchronous deassert expected upstream): state EMPTY, in_ready all 1, out_valid 0, out_* payload 0, stall_cnt 0, stall_timeout 0, any_stall 0.
- Latency: message enqueued in cycle N visible on out_* in cycle N+1.
- Throughput: one message per cycle per channel with out_ready held high.
- Reset mid-stall: all buffered messages dropped, counters and flags cleared immediately.
- Counter wrap-around forbidden; saturation at 255 (CNT_W=8).

## Structure
- Shared package l2_msg_pkg: msg type constants, TYPE_W/TAG_W/DATA_W defaults, channel-state enum {EMPTY, ONE, TWO}.
- Sub-module l2_msg_skid_ch: one channel (2-entry buffer, stall counter, timeout); top generates NUM_CH instances and ORs any_stall.

## Test plan
- Reset then idle: in_ready=3'b111, out_valid=0, stall_cnt all 0, no timeout.
- Ch0 enqueue type 8'h12 tag 26'h1 with out_ready=1: out_valid[0] next cycle, accepted, back to EMPTY; stall_cnt[0] stays 0.
- Ch1 out_ready=0, enqueue two messages: in_ready[1] drops after second; out_* bit-stable 10 cycles, stall_cnt[1]=10; raise out_ready: first then second message drained in order, cnt returns 0.
- Ch2 stalled 200 cycles: stall_timeout[2] rises when stall_cnt=200; stall continues to 300 -> cnt saturates 255; pulse clear_timeout[2] while cnt≥200: flag stays set (set wins).
- Simultaneous enq+deq in ONE on all channels for 50 cycles: no back-pressure, in-order delivery, no state change.
- Assert rst low while ch1 in TWO and stalled: out_valid[1]=0, stall_cnt[1]=0, timeout cleared asynchronously.
